// File: rtl/inst_fetch_pkg.sv
// Shared fetch constants and types, also used by the decode and branch units.
package inst_fetch_pkg;

    localparam int                PC_W             = 32;
    localparam int                INST_W           = 32;
    localparam logic [PC_W-1:0]   RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [PC_W-1:0]   INST_BYTES       = 32'd4;
    localparam logic [INST_W-1:0] NOP_INST         = 32'h0000_0000;

    typedef enum logic [1:0] {
        OP_ADVANCE,
        OP_STALL,
        OP_REDIRECT
    } fetch_op_e;

    function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
        return {addr[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-stage bus: instruction memory request/return plus the decode-facing stream.
interface inst_fetch_if;
    import inst_fetch_pkg::*;

    logic [PC_W-1:0]   imem_addr;
    logic [INST_W-1:0] imem_inst;
    logic              stall;
    logic              redirect;
    logic [PC_W-1:0]   redirect_pc;
    logic              if_valid;
    logic [INST_W-1:0] if_inst;
    logic [PC_W-1:0]   if_pc;
    logic [PC_W-1:0]   if_pc_plus4;
    logic              misalign_err;

    modport master (
        output imem_addr,
        input  imem_inst,
        input  stall,
        input  redirect,
        input  redirect_pc,
        output if_valid,
        output if_inst,
        output if_pc,
        output if_pc_plus4,
        output misalign_err
    );

    modport slave (
        input  imem_addr,
        output imem_inst,
        output stall,
        output redirect,
        output redirect_pc,
        input  if_valid,
        input  if_inst,
        input  if_pc,
        input  if_pc_plus4,
        input  misalign_err
    );

endinterface

// File: rtl/inst_fetch_hold_buf.sv
// Captures the current word on the first stalled cycle so decode sees it unchanged
// while IMem keeps returning the speculative next word.
module fetch_hold_buf
    import inst_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  fetch_op_e         op,
    input  logic              req_valid,
    input  logic [INST_W-1:0] imem_inst,
    output logic [INST_W-1:0] if_inst
);

    logic [INST_W-1:0] hold_inst_q, hold_inst_d;
    logic              hold_valid_q, hold_valid_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first; a branch that skips one infers a latch.
        hold_inst_d  = hold_inst_q;
        hold_valid_d = hold_valid_q;
        case (op)
            OP_STALL: begin
                if (req_valid && !hold_valid_q) begin
                    hold_inst_d  = imem_inst;
                    hold_valid_d = 1'b1;
                end
            end
            default: hold_valid_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_inst_q  <= NOP_INST;
            hold_valid_q <= 1'b0;
        end else begin
            // NOTE: flops use <= so each one samples pre-edge values regardless of statement order.
            hold_inst_q  <= hold_inst_d;
            hold_valid_q <= hold_valid_d;
        end
    end

    assign if_inst = !req_valid   ? NOP_INST    :
                     hold_valid_q ? hold_inst_q : imem_inst;

endmodule

// File: rtl/inst_fetch.sv
// PC sequencer in front of a one-cycle-latency IMem; zero-bubble redirects and
// stall-stable instruction/PC pairs for decode.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    inst_fetch_if.master  fi
);

    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] req_pc_q, req_pc_d;
    logic            req_valid_q, req_valid_d;
    logic            misalign_q, misalign_d;
    logic [PC_W-1:0] tgt;
    fetch_op_e       op;

    // Redirect wins over stall: the instruction on display is consumed by it.
    always_comb begin
        if (fi.redirect)   op = OP_REDIRECT;
        else if (fi.stall) op = OP_STALL;
        else               op = OP_ADVANCE;
    end

    assign tgt          = word_align(fi.redirect_pc);
    assign fi.imem_addr = (op == OP_REDIRECT) ? tgt : pc_q;

    always_comb begin
        pc_d        = pc_q;
        req_pc_d    = req_pc_q;
        req_valid_d = req_valid_q;
        misalign_d  = misalign_q;
        case (op)
            OP_REDIRECT: begin
                req_pc_d    = tgt;
                req_valid_d = 1'b1;
                pc_d        = tgt + INST_BYTES;
                if (fi.redirect_pc[1:0] != 2'b00) misalign_d = 1'b1;
            end
            OP_ADVANCE: begin
                req_pc_d    = pc_q;
                req_valid_d = 1'b1;
                pc_d        = pc_q + INST_BYTES;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            req_pc_q    <= RESET_PC;
            req_valid_q <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            req_valid_q <= req_valid_d;
            misalign_q  <= misalign_d;
        end
    end

    fetch_hold_buf u_hold (
        .clk       (clk),
        .rst       (rst),
        .op        (op),
        .req_valid (req_valid_q),
        .imem_inst (fi.imem_inst),
        .if_inst   (fi.if_inst)
    );

    assign fi.if_valid     = req_valid_q;
    assign fi.if_pc        = req_pc_q;
    assign fi.if_pc_plus4  = req_pc_q + INST_BYTES;
    assign fi.misalign_err = misalign_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: two instances (RESET_PC 0 and 0x100) sharing one IMem image.
module tb_inst_fetch;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    inst_fetch_if f0 ();
    inst_fetch_if f1 ();

    inst_fetch #(.RESET_PC(32'h0000_0000)) u0 (.clk(clk), .rst(rst), .fi(f0));
    inst_fetch #(.RESET_PC(32'h0000_0100)) u1 (.clk(clk), .rst(rst), .fi(f1));

    // Unlisted words are 32'hC0DE_00<index> so every address returns a distinct value.
    logic [31:0] mem [0:255];
    always @(posedge clk) begin
        f0.imem_inst <= mem[f0.imem_addr[9:2]];
        f1.imem_inst <= mem[f1.imem_addr[9:2]];
    end

    int          passed = 0;
    int          total  = 0;
    logic [96:0] got, exp;

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        f0.stall = 1'b0; f0.redirect = 1'b0; f0.redirect_pc = 32'h0;
        f1.stall = 1'b0; f1.redirect = 1'b0; f1.redirect_pc = 32'h0;
        repeat (2) @(posedge clk);
        #3;
        total++; got = {f0.if_valid, f0.if_pc, f0.if_pc_plus4, f0.if_inst};
        exp = {1'b0, 32'h0, 32'h4, 32'h0};
        if (got !== exp) $display("FAIL reset_u0: got %h want %h", got, exp); else passed++;
        total++;
        if (f0.imem_addr !== 32'h0 || f0.misalign_err !== 1'b0)
            $display("FAIL reset_u0_addr: got %h/%b want 0/0", f0.imem_addr, f0.misalign_err);
        else passed++;
        total++; got = {f1.if_valid, f1.if_pc, f1.if_pc_plus4, f1.if_inst};
        exp = {1'b0, 32'h100, 32'h104, 32'h0};
        if (got !== exp) $display("FAIL reset_u1: got %h want %h", got, exp); else passed++;
        rst = 1'b0;
        #1;
        total++;
        if (f0.if_valid !== 1'b0 || f0.imem_addr !== 32'h0)
            $display("FAIL cycle1: got valid %b addr %h want 0/0", f0.if_valid, f0.imem_addr);
        else passed++;
    endtask

    task automatic test_free_run;
        logic [31:0] words [4];
        words = '{32'h20080005, 32'h20090003, 32'h01095020, 32'h00000000};
        for (int k = 0; k < 4; k++) begin
            tick(); #1;
            total++; got = {f0.if_valid, f0.if_pc, f0.if_pc_plus4, f0.if_inst};
            exp = {1'b1, 32'(4 * k), 32'(4 * k + 4), words[k]};
            if (got !== exp) $display("FAIL free_run[%0d]: got %h want %h", k, got, exp); else passed++;
        end
    endtask

    task automatic test_stall;
        f0.redirect = 1'b1; f0.redirect_pc = 32'h4;
        tick();
        f0.redirect = 1'b0; f0.stall = 1'b1;
        #1;
        total++; got = {f0.if_valid, f0.if_pc, f0.if_pc_plus4, f0.if_inst};
        exp = {1'b1, 32'h4, 32'h8, 32'h20090003};
        if (got !== exp) $display("FAIL stall_enter: got %h want %h", got, exp); else passed++;
        for (int s = 0; s < 2; s++) begin
            tick(); #1;
            total++; got = {f0.if_valid, f0.if_pc, f0.if_pc_plus4, f0.if_inst};
            if (got !== exp) $display("FAIL stall_hold[%0d]: got %h want %h", s, got, exp); else passed++;
            total++;
            if (f0.imem_addr !== 32'h8) $display("FAIL stall_addr[%0d]: got %h want 8", s, f0.imem_addr);
            else passed++;
        end
        tick();
        f0.stall = 1'b0;
        #1;
        total++; got = {f0.if_valid, f0.if_pc, f0.if_pc_plus4, f0.if_inst};
        if (got !== exp) $display("FAIL stall_release: got %h want %h", got, exp); else passed++;
        tick(); #1;
        total++; got = {f0.if_valid, f0.if_pc, f0.if_pc_plus4, f0.if_inst};
        exp = {1'b1, 32'h8, 32'hC, 32'h01095020};
        if (got !== exp) $display("FAIL stall_next: got %h want %h", got, exp); else passed++;
    endtask

    task automatic test_redirect;
        f0.redirect = 1'b1; f0.redirect_pc = 32'h40;
        #1;
        total++;
        if (f0.imem_addr !== 32'h40) $display("FAIL redir_addr: got %h want 40", f0.imem_addr); else passed++;
        tick();
        f0.redirect = 1'b0;
        #1;
        total++; got = {f0.if_valid, f0.if_pc, f0.if_pc_plus4, f0.if_inst};
        exp = {1'b1, 32'h40, 32'h44, 32'hC0DE0010};
        if (got !== exp) $display("FAIL redir_target: got %h want %h", got, exp); else passed++;
        total++;
        if (f0.misalign_err !== 1'b0) $display("FAIL redir_misalign: got %b want 0", f0.misalign_err);
        else passed++;
        tick(); #1;
        total++; got = {f0.if_valid, f0.if_pc, f0.if_pc_plus4, f0.if_inst};
        exp = {1'b1, 32'h44, 32'h48, 32'hC0DE0011};
        if (got !== exp) $display("FAIL redir_seq: got %h want %h", got, exp); else passed++;
    endtask

    task automatic test_redirect_stall;
        f0.stall = 1'b1;
        tick();
        f0.redirect = 1'b1; f0.redirect_pc = 32'h80;
        #1;
        total++; got = {f0.if_valid, f0.if_pc, f0.if_pc_plus4, f0.if_inst};
        exp = {1'b1, 32'h44, 32'h48, 32'hC0DE0011};
        if (got !== exp) $display("FAIL rs_held: got %h want %h", got, exp); else passed++;
        total++;
        if (f0.imem_addr !== 32'h80) $display("FAIL rs_addr: got %h want 80", f0.imem_addr); else passed++;
        tick();
        f0.redirect = 1'b0; f0.stall = 1'b0;
        #1;
        total++; got = {f0.if_valid, f0.if_pc, f0.if_pc_plus4, f0.if_inst};
        exp = {1'b1, 32'h80, 32'h84, 32'hC0DE0020};
        if (got !== exp) $display("FAIL rs_target: got %h want %h", got, exp); else passed++;
        tick(); #1;
        total++; got = {f0.if_valid, f0.if_pc, f0.if_pc_plus4, f0.if_inst};
        exp = {1'b1, 32'h84, 32'h88, 32'hC0DE0021};
        if (got !== exp) $display("FAIL rs_seq: got %h want %h", got, exp); else passed++;
    endtask

    task automatic test_misalign;
        f0.redirect = 1'b1; f0.redirect_pc = 32'h42;
        #1;
        total++;
        if (f0.imem_addr !== 32'h40) $display("FAIL mis_addr: got %h want 40", f0.imem_addr); else passed++;
        tick();
        f0.redirect = 1'b0;
        #1;
        total++; got = {f0.if_valid, f0.if_pc, f0.if_pc_plus4, f0.if_inst};
        exp = {1'b1, 32'h40, 32'h44, 32'hC0DE0010};
        if (got !== exp) $display("FAIL mis_target: got %h want %h", got, exp); else passed++;
        total++;
        if (f0.misalign_err !== 1'b1) $display("FAIL mis_set: got %b want 1", f0.misalign_err); else passed++;
        f0.redirect = 1'b1; f0.redirect_pc = 32'h8;
        tick();
        f0.redirect = 1'b0;
        #1;
        total++; got = {f0.if_valid, f0.if_pc, f0.if_pc_plus4, f0.if_inst};
        exp = {1'b1, 32'h8, 32'hC, 32'h01095020};
        if (got !== exp) $display("FAIL mis_aligned_redir: got %h want %h", got, exp); else passed++;
        tick(); #1;
        total++;
        if (f0.misalign_err !== 1'b1) $display("FAIL mis_sticky: got %b want 1", f0.misalign_err); else passed++;
    endtask

    task automatic test_rst_mid_stall;
        f0.stall = 1'b1;
        tick();
        #2;
        rst = 1'b1;
        #1;
        total++; got = {f0.if_valid, f0.if_pc, f0.if_pc_plus4, f0.if_inst};
        exp = {1'b0, 32'h0, 32'h4, 32'h0};
        if (got !== exp) $display("FAIL arst_u0: got %h want %h", got, exp); else passed++;
        total++;
        if (f0.imem_addr !== 32'h0 || f0.misalign_err !== 1'b0)
            $display("FAIL arst_u0_addr: got %h/%b want 0/0", f0.imem_addr, f0.misalign_err);
        else passed++;
        total++; got = {f1.if_valid, f1.if_pc, f1.if_pc_plus4, f1.if_inst};
        exp = {1'b0, 32'h100, 32'h104, 32'h0};
        if (got !== exp) $display("FAIL arst_u1: got %h want %h", got, exp); else passed++;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (f1.if_valid !== 1'b0 || f1.imem_addr !== 32'h100)
            $display("FAIL u1_cycle1: got valid %b addr %h want 0/100", f1.if_valid, f1.imem_addr);
        else passed++;
        tick();
        f0.stall = 1'b0;
        #1;
        total++; got = {f0.if_valid, f0.if_pc, f0.if_pc_plus4, f0.if_inst};
        exp = {1'b0, 32'h0, 32'h4, 32'h0};
        if (got !== exp) $display("FAIL stall_no_valid: got %h want %h", got, exp); else passed++;
        total++; got = {f1.if_valid, f1.if_pc, f1.if_pc_plus4, f1.if_inst};
        exp = {1'b1, 32'h100, 32'h104, 32'hC0DE0040};
        if (got !== exp) $display("FAIL u1_first: got %h want %h", got, exp); else passed++;
        tick(); #1;
        total++; got = {f0.if_valid, f0.if_pc, f0.if_pc_plus4, f0.if_inst};
        exp = {1'b1, 32'h0, 32'h4, 32'h20080005};
        if (got !== exp) $display("FAIL after_stall_no_valid: got %h want %h", got, exp); else passed++;
        total++; got = {f1.if_valid, f1.if_pc, f1.if_pc_plus4, f1.if_inst};
        exp = {1'b1, 32'h104, 32'h108, 32'hC0DE0041};
        if (got !== exp) $display("FAIL u1_second: got %h want %h", got, exp); else passed++;
    endtask

    task automatic test_wrap;
        f1.redirect = 1'b1; f1.redirect_pc = 32'hFFFF_FFFC;
        #1;
        total++;
        if (f1.imem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_addr: got %h want fffffffc", f1.imem_addr);
        else passed++;
        tick();
        f1.redirect = 1'b0;
        #1;
        total++; got = {f1.if_valid, f1.if_pc, f1.if_pc_plus4, f1.if_inst};
        exp = {1'b1, 32'hFFFF_FFFC, 32'h0, 32'hC0DE00FF};
        if (got !== exp) $display("FAIL wrap_top: got %h want %h", got, exp); else passed++;
        tick(); #1;
        total++; got = {f1.if_valid, f1.if_pc, f1.if_pc_plus4, f1.if_inst};
        exp = {1'b1, 32'h0, 32'h4, 32'h20080005};
        if (got !== exp) $display("FAIL wrap_zero: got %h want %h", got, exp); else passed++;
        total++;
        if (f1.misalign_err !== 1'b0) $display("FAIL wrap_misalign: got %b want 0", f1.misalign_err);
        else passed++;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
        mem[0] = 32'h20080005;
        mem[1] = 32'h20090003;
        mem[2] = 32'h01095020;
        mem[3] = 32'h00000000;
        test_reset();
        test_free_run();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_misalign();
        test_rst_mid_stall();
        test_wrap();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Program-counter and fetch-sequencing stage sitting directly upstream of the instruction memory. It drives the IMem word address, pairs each instruction returned one cycle later with its PC, and holds that pair stable while decode stalls. It applies branch/jump/jal/jr redirects with zero bubble and presents decode with a registered-PC instruction stream that is valid-qualified.

## Interface
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- imem_addr  out  32  byte address to IMem; IMem samples it at posedge clk and returns the word next cycle.
- imem_inst  in  32  IMem read data for the address presented in the previous cycle.
- stall  in  1  decode cannot accept the current instruction; hold outputs.
- redirect  in  1  current instruction is consumed and control flow changes.
- redirect_pc  in  32  redirect target byte address.
- if_valid  out  1  if_inst/if_pc describe a real instruction.
- if_inst  out  32  instruction word; 32'h0 (nop) when if_valid=0.
- if_pc  out  32  byte address of if_inst.
- if_pc_plus4  out  32  if_pc+4, the jal link value.
- misalign_err  out  1  sticky; set by a redirect target with nonzero bits [1:0].

## Operation
- State: pc (next address to request), req_pc (address of the word on imem_inst), req_valid, hold_inst, hold_valid, misalign_err.
- Reset values: pc=req_pc=RESET_PC, req_valid=0, hold_valid=0, hold_inst=0, misalign_err=0. Outputs in reset: if_valid=0, if_inst=0, if_pc=RESET_PC, if_pc_plus4=RESET_PC+4, imem_addr=RESET_PC.
- Outputs: if_valid=req_valid; if_inst = !req_valid ? 0 : hold_valid ? hold_inst : imem_inst; if_pc=req_pc.
- Priority each cycle: redirect > stall > advance.
- Redirect (stall ignored): tgt={redirect_pc[31:2],2'b00}; imem_addr=tgt combinationally. At the edge: req_pc<=tgt, req_valid<=1, pc<=tgt+4, hold_valid<=0. If redirect_pc[1:0]!=0, misalign_err<=1, and it stays set until rst.
- Stall (no redirect): imem_addr=pc, and the word IMem returns is discarded. pc, req_pc, and req_valid hold. If req_valid & !hold_valid, then hold_inst<=imem_inst and hold_valid<=1. if_inst is therefore unchanged for the whole stall.
- Advance: imem_addr=pc. At the edge: req_pc<=pc, req_valid<=1, pc<=pc+4, hold_valid<=0.
- Arithmetic: all PC adds are 32-bit modulo 2^32. 32'hFFFF_FFFC+4 wraps to 0 with no flag.
- Stall while req_valid=0: nothing is captured, and the first advance then proceeds normally.

## Timing
- Fetch latency: 1 cycle from address presentation to if_valid. The first valid instruction appears in the 2nd cycle after rst deasserts.
- Redirect penalty: 0 bubbles. The target's instruction is valid the cycle after redirect.
- Stall release: the held word is output in the release cycle. The next sequential word follows the next cycle, with no bubble and no duplicate.
- Combinational paths: redirect/redirect_pc→imem_addr and imem_inst→if_inst. All other outputs are registered.
- rst asserted mid-stream: state clears immediately, and any held instruction is dropped.

## Structure
- Shared package: RESET_PC default, INST_BYTES=4, NOP_INST=32'h0, and the PC width constant, reused by the decode/branch units.
- One natural sub-module: fetch_hold_buf (hold_inst/hold_valid register plus output mux). The rest is flat.

## Test plan
- Reset then free run, with mem[0..3]=32'h20080005, 32'h20090003, 32'h01095020, 32'h0 → cycle 1: if_valid=0. Cycles 2–5: if_pc=0,4,8,C with matching words, if_pc_plus4=if_pc+4.
- Stall 3 cycles while if_pc=4 → if_inst=32'h20090003 and if_pc=4 held for all 3 cycles. The release cycle still shows pc 4, then pc 8. No skip and no duplicate.
- Redirect to 32'h40 while at pc 8 → the next cycle shows if_pc=32'h40 with mem[16], then 32'h44. misalign_err=0.
- Redirect and stall together to 32'h80 → redirect wins: the next cycle shows if_pc=32'h80, and hold_valid is cleared.
- Redirect to 32'h42 → fetch from 32'h40, misalign_err=1, and it stays 1 until rst.
- Async rst pulse mid-stall, then RESET_PC=32'h100 variant, wrap check → outputs are at reset values immediately. The first fetch is 32'h100. A redirect to 32'hFFFF_FFFC is followed by if_pc=0.
